// File: rtl/nn_vga_cursor_if.sv
// CPU-to-display bundle for the VGA cursor back-end: cursor coordinates in,
// sync/qualifier/colour/frame marker out.
interface nn_vga_cursor_if;
    logic [31:0] VGA_X;
    logic [31:0] VGA_Y;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_DE;
    logic [3:0]  VGA_R;
    logic [3:0]  VGA_G;
    logic [3:0]  VGA_B;
    logic        FRAME_START;

    // Driver of the coordinates, consumer of the video stream
    modport master (
        output VGA_X, VGA_Y,
        input  VGA_HS, VGA_VS, VGA_DE, VGA_R, VGA_G, VGA_B, FRAME_START
    );

    // The display back-end itself
    modport slave (
        input  VGA_X, VGA_Y,
        output VGA_HS, VGA_VS, VGA_DE, VGA_R, VGA_G, VGA_B, FRAME_START
    );
endinterface

// File: rtl/nn_vga_cursor.sv
// VGA timing generator with a solid square cursor on a flat background.
// Cursor coordinates are latched once per frame on the last pixel tick so a
// mid-frame CPU write never tears the picture. All outputs are registered on
// the pixel tick from the pre-increment counters, so sync, DE and colour are
// aligned with no skew.
module nn_vga_cursor #(
    parameter int          CLK_DIV     = 2,
    parameter int          H_ACTIVE    = 640,
    parameter int          H_FP        = 16,
    parameter int          H_SYNC      = 96,
    parameter int          H_BP        = 48,
    parameter int          V_ACTIVE    = 480,
    parameter int          V_FP        = 10,
    parameter int          V_SYNC      = 2,
    parameter int          V_BP        = 33,
    parameter int          CURSOR_SIZE = 8,
    parameter logic [11:0] FG_COLOR    = 12'hFFF,
    parameter logic [11:0] BG_COLOR    = 12'h008
) (
    input  logic            CLK,
    input  logic            RST_N,
    nn_vga_cursor_if.slave  bus
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W      = $clog2(H_TOTAL);
    localparam int V_W      = $clog2(V_TOTAL);
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [DIV_W-1:0] r_div_cnt;
    logic [H_W-1:0]   r_h_cnt;
    logic [V_W-1:0]   r_v_cnt;
    logic [31:0]      r_cur_x;
    logic [31:0]      r_cur_y;
    logic             r_hs;
    logic             r_vs;
    logic             r_de;
    logic             r_fs;
    logic [11:0]      r_rgb;

    logic             w_pix_tick;
    logic [31:0]      w_h32;
    logic [31:0]      w_v32;
    logic             w_h_last;
    logic             w_v_last;
    logic             w_hs_n;
    logic             w_vs_n;
    logic             w_de;
    logic [32:0]      w_h_ext;
    logic [32:0]      w_v_ext;
    logic [32:0]      w_x_lo;
    logic [32:0]      w_y_lo;
    logic [32:0]      w_x_hi;
    logic [32:0]      w_y_hi;
    logic             w_inside;

    // With CLK_DIV=1 every system clock is a pixel clock
    assign w_pix_tick = (CLK_DIV == 1) ? 1'b1 : (r_div_cnt == DIV_W'(CLK_DIV - 1));

    assign w_h32    = 32'(r_h_cnt);
    assign w_v32    = 32'(r_v_cnt);
    assign w_h_last = (w_h32 == 32'(H_TOTAL - 1));
    assign w_v_last = (w_v32 == 32'(V_TOTAL - 1));

    assign w_hs_n = !((w_h32 >= 32'(HS_START)) && (w_h32 < 32'(HS_END)));
    assign w_vs_n = !((w_v32 >= 32'(VS_START)) && (w_v32 < 32'(VS_END)));
    assign w_de   = (w_h32 < 32'(H_ACTIVE)) && (w_v32 < V_ACTIVE);

    // 33-bit bounds keep cur+size from wrapping; an off-screen cursor simply
    // never overlaps an active pixel, so it is hidden by DE
    assign w_h_ext  = {1'b0, w_h32};
    assign w_v_ext  = {1'b0, w_v32};
    assign w_x_lo   = {1'b0, r_cur_x};
    assign w_y_lo   = {1'b0, r_cur_y};
    assign w_x_hi   = w_x_lo + 33'(CURSOR_SIZE);
    assign w_y_hi   = w_y_lo + 33'(CURSOR_SIZE);
    assign w_inside = (w_h_ext >= w_x_lo) && (w_h_ext < w_x_hi) &&
                      (w_v_ext >= w_y_lo) && (w_v_ext < w_y_hi);

    // Pixel-rate divider
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_div_cnt <= '0;
        end else if (w_pix_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Raster position: h advances per pixel tick, v on the h wrap
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_pix_tick) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    // Cursor latch on the final pixel tick of the frame; reset parks it off-screen
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cur_x <= 32'(H_ACTIVE);
            r_cur_y <= 32'(V_ACTIVE);
        end else if (w_pix_tick && w_h_last && w_v_last) begin
            r_cur_x <= bus.VGA_X;
            r_cur_y <= bus.VGA_Y;
        end
    end

    // Registered video outputs decoded from the current raster position
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
            r_de  <= 1'b0;
            r_rgb <= '0;
        end else if (w_pix_tick) begin
            r_hs  <= w_hs_n;
            r_vs  <= w_vs_n;
            r_de  <= w_de;
            r_rgb <= w_de ? (w_inside ? FG_COLOR : BG_COLOR) : 12'h000;
        end
    end

    // Frame marker: one CLK wide, coincident with pixel (0,0) appearing
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_fs <= 1'b0;
        end else begin
            r_fs <= w_pix_tick && (r_h_cnt == '0) && (r_v_cnt == '0);
        end
    end

    assign bus.VGA_HS      = r_hs;
    assign bus.VGA_VS      = r_vs;
    assign bus.VGA_DE      = r_de;
    assign bus.VGA_R       = r_rgb[11:8];
    assign bus.VGA_G       = r_rgb[7:4];
    assign bus.VGA_B       = r_rgb[3:0];
    assign bus.FRAME_START = r_fs;

endmodule

// File: tb/tb_nn_vga_cursor.sv
// Bench for nn_vga_cursor on a reduced raster (24x17 totals) so whole frames
// fit in a short run. A reference model derives the expected output for every
// CLK from the edge count since reset release and queues it; a monitor pops
// and compares on the falling edge and keeps per-frame statistics.
module tb_nn_vga_cursor;

    localparam int CLK_DIV  = 2;
    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 3;
    localparam int V_ACTIVE = 12;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 2;
    localparam int CS       = 4;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME_CLKS = H_TOTAL * V_TOTAL * CLK_DIV;
    localparam logic [11:0] FG = 12'hFFF;
    localparam logic [11:0] BG = 12'h008;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    nn_vga_cursor_if bus();

    nn_vga_cursor #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CURSOR_SIZE(CS), .FG_COLOR(FG), .BG_COLOR(BG)
    ) dut (
        .CLK(clk),
        .RST_N(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          h;
        int          v;
        logic        tick;
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [11:0] rgb;
    } exp_t;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        int          cnt;
        int          xmin;
        int          xmax;
        int          ymin;
        int          ymax;
    } vec_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    int     m_edge;
    longint m_cx, m_cy;
    exp_t   m_cur;
    int     p_pix, p_h, p_v;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_edge = 0;
            m_cx = H_ACTIVE;
            m_cy = V_ACTIVE;
            m_cur.h = 0; m_cur.v = 0; m_cur.tick = 1'b0;
            m_cur.hs = 1'b1; m_cur.vs = 1'b1; m_cur.de = 1'b0; m_cur.fs = 1'b0;
            m_cur.rgb = 12'h000;
            q.delete();
        end else begin
            m_edge++;
            m_cur.fs = 1'b0;
            m_cur.tick = ((m_edge % CLK_DIV) == 0);
            if (m_cur.tick) begin
                p_pix = m_edge / CLK_DIV - 1;
                p_h = p_pix % H_TOTAL;
                p_v = (p_pix / H_TOTAL) % V_TOTAL;
                m_cur.h  = p_h;
                m_cur.v  = p_v;
                m_cur.hs = !(p_h >= 18 && p_h <= 20);
                m_cur.vs = !(p_v >= 13 && p_v <= 14);
                m_cur.de = (p_h < H_ACTIVE) && (p_v < V_ACTIVE);
                if (!m_cur.de)
                    m_cur.rgb = 12'h000;
                else if (p_h >= m_cx && p_h < m_cx + CS && p_v >= m_cy && p_v < m_cy + CS)
                    m_cur.rgb = FG;
                else
                    m_cur.rgb = BG;
                m_cur.fs = (p_h == 0) && (p_v == 0);
                if (p_h == H_TOTAL - 1 && p_v == V_TOTAL - 1) begin
                    m_cx = longint'(bus.VGA_X);
                    m_cy = longint'(bus.VGA_Y);
                end
            end
            q.push_back(m_cur);
        end
    end

    // ---------------- monitor ----------------
    exp_t        c_e;
    logic [15:0] got;
    logic [11:0] got_rgb;
    int f_clks = 0, f_hs = 0, f_vs = 0, f_bad = 0, f_fg = 0;
    int f_xmin = 9999, f_xmax = -1, f_ymin = 9999, f_ymax = -1;
    int l_clks = 0, l_hs = 0, l_vs = 0, l_bad = 0, l_fg = 0;
    int l_xmin = 0, l_xmax = 0, l_ymin = 0, l_ymax = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            got_rgb = {bus.VGA_R, bus.VGA_G, bus.VGA_B};
            got = {bus.VGA_HS, bus.VGA_VS, bus.VGA_DE, bus.FRAME_START, got_rgb};
            c_e.tick = 1'b0;
            if (q.size() > 0) begin
                c_e = q.pop_front();
                checks++;
                if (got !== {c_e.hs, c_e.vs, c_e.de, c_e.fs, c_e.rgb}) begin
                    errors++;
                    $display("FAIL pixel h=%0d v=%0d got {hs,vs,de,fs,rgb}=%h want %h",
                             c_e.h, c_e.v, got, {c_e.hs, c_e.vs, c_e.de, c_e.fs, c_e.rgb});
                end
            end
            if (bus.FRAME_START) begin
                l_clks = f_clks; l_hs = f_hs; l_vs = f_vs; l_bad = f_bad; l_fg = f_fg;
                l_xmin = f_xmin; l_xmax = f_xmax; l_ymin = f_ymin; l_ymax = f_ymax;
                f_clks = 0; f_hs = 0; f_vs = 0; f_bad = 0; f_fg = 0;
                f_xmin = 9999; f_xmax = -1; f_ymin = 9999; f_ymax = -1;
            end
            f_clks++;
            if (!bus.VGA_HS) f_hs++;
            if (!bus.VGA_VS) f_vs++;
            if (bus.VGA_DE && (!bus.VGA_HS || !bus.VGA_VS)) f_bad++;
            if (c_e.tick && bus.VGA_DE && got_rgb == FG) begin
                f_fg++;
                if (c_e.h < f_xmin) f_xmin = c_e.h;
                if (c_e.h > f_xmax) f_xmax = c_e.h;
                if (c_e.v < f_ymin) f_ymin = c_e.v;
                if (c_e.v > f_ymax) f_ymax = c_e.v;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Waits for n frame-start pulses; returns just after a rising edge
    task automatic wait_fs(input int n);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < (n + 1) * FRAME_CLKS + 10) begin
            @(negedge clk);
            cyc++;
            if (bus.FRAME_START) seen++;
        end
        checks++;
        if (seen < n) begin
            errors++;
            $display("FAIL frame_start_timeout got %0d pulses want %0d", seen, n);
        end
        @(posedge clk);
        #1;
    endtask

    // Releases reset and counts rising edges until FRAME_START is seen
    task automatic release_count(output int n);
        rst_n = 1'b1;
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.FRAME_START) break;
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[8];
    int   n_edges;
    logic [15:0] rst_vals;

    initial begin
        tbl[0] = '{x: 32'd5,          y: 32'd3,          cnt: 16, xmin: 5,  xmax: 8,  ymin: 3,  ymax: 6};
        tbl[1] = '{x: 32'd0,          y: 32'd0,          cnt: 16, xmin: 0,  xmax: 3,  ymin: 0,  ymax: 3};
        tbl[2] = '{x: 32'd14,         y: 32'd10,         cnt: 4,  xmin: 14, xmax: 15, ymin: 10, ymax: 11};
        tbl[3] = '{x: 32'd15,         y: 32'd11,         cnt: 1,  xmin: 15, xmax: 15, ymin: 11, ymax: 11};
        tbl[4] = '{x: 32'h8000_0000,  y: 32'd3,          cnt: 0,  xmin: 0,  xmax: 0,  ymin: 0,  ymax: 0};
        tbl[5] = '{x: 32'd5,          y: 32'd12,         cnt: 0,  xmin: 0,  xmax: 0,  ymin: 0,  ymax: 0};
        tbl[6] = '{x: 32'hFFFF_FFFF,  y: 32'hFFFF_FFFF,  cnt: 0,  xmin: 0,  xmax: 0,  ymin: 0,  ymax: 0};
        tbl[7] = '{x: 32'd16,         y: 32'd0,          cnt: 0,  xmin: 0,  xmax: 0,  ymin: 0,  ymax: 0};

        bus.VGA_X = 32'd5;
        bus.VGA_Y = 32'd3;
        #2 rst_n = 1'b0;
        step(3);
        rst_vals = {bus.VGA_HS, bus.VGA_VS, bus.VGA_DE, bus.FRAME_START, bus.VGA_R, bus.VGA_G, bus.VGA_B};
        check("reset_outputs", 64'(rst_vals), 64'h0000_0000_0000_C000);

        // First pixel tick lands on edge CLK_DIV after release
        release_count(n_edges);
        check("first_fs_edge", 64'(n_edges), 64'(CLK_DIV));
        wait_fs(1);
        check("frame0_hidden_fg", 64'(l_fg), 64'd0);
        check("frame0_clks", 64'(l_clks), 64'(FRAME_CLKS));

        // Table: coordinates held, measure the first fully latched frame
        for (int i = 0; i < 8; i++) begin
            bus.VGA_X = tbl[i].x;
            bus.VGA_Y = tbl[i].y;
            wait_fs(3);
            check($sformatf("fg_count[%0d]", i), 64'(l_fg), 64'(tbl[i].cnt));
            if (tbl[i].cnt > 0)
                check($sformatf("fg_bbox[%0d]", i),
                      {16'(l_xmin), 16'(l_xmax), 16'(l_ymin), 16'(l_ymax)},
                      {16'(tbl[i].xmin), 16'(tbl[i].xmax), 16'(tbl[i].ymin), 16'(tbl[i].ymax)});
        end

        // Frame geometry of the last full frame
        check("frame_clks", 64'(l_clks), 64'(FRAME_CLKS));
        check("hs_low_clks", 64'(l_hs), 64'(H_SYNC * CLK_DIV * V_TOTAL));
        check("vs_low_clks", 64'(l_vs), 64'(V_SYNC * H_TOTAL * CLK_DIV));
        check("de_during_sync", 64'(l_bad), 64'd0);

        // Mid-frame write must not take effect until the next frame
        bus.VGA_X = 32'd5;
        bus.VGA_Y = 32'd3;
        wait_fs(3);
        step(8 * H_TOTAL * CLK_DIV);
        bus.VGA_X = 32'd10;
        wait_fs(1);
        check("midwrite_old_frame", {32'(l_xmin), 32'(l_xmax)}, {32'd5, 32'd8});
        wait_fs(1);
        check("midwrite_new_frame", {32'(l_xmin), 32'(l_xmax)}, {32'd10, 32'd13});

        // Coordinates changing every CLK, including on the latch edge
        for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
            bus.VGA_X = 32'($urandom_range(0, 20));
            bus.VGA_Y = 32'($urandom_range(0, 15));
            step(1);
        end

        // Mid-frame asynchronous reset
        bus.VGA_X = 32'd5;
        bus.VGA_Y = 32'd3;
        wait_fs(3);
        step((6 * H_TOTAL + 12) * CLK_DIV);
        rst_n = 1'b0;
        #1;
        rst_vals = {bus.VGA_HS, bus.VGA_VS, bus.VGA_DE, bus.FRAME_START, bus.VGA_R, bus.VGA_G, bus.VGA_B};
        check("async_reset_outputs", 64'(rst_vals), 64'h0000_0000_0000_C000);
        step(3);
        rst_vals = {bus.VGA_HS, bus.VGA_VS, bus.VGA_DE, bus.FRAME_START, bus.VGA_R, bus.VGA_G, bus.VGA_B};
        check("reset_held_outputs", 64'(rst_vals), 64'h0000_0000_0000_C000);
        release_count(n_edges);
        check("restart_fs_edge", 64'(n_edges), 64'(CLK_DIV));
        wait_fs(1);
        check("restart_hidden_fg", 64'(l_fg), 64'd0);
        wait_fs(1);
        check("restart_next_fg", 64'(l_fg), 64'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
